// File: rtl/cv32e40p_fetch_aligner_if.sv
// Handshake bundle between the prefetch buffer, the fetch aligner and the ID stage.
// The aligner connects through the slave modport; the environment (prefetch
// buffer and ID stage, or a testbench) connects through the master modport.
interface cv32e40p_fetch_aligner_if;
    // prefetch buffer side
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    // control-flow redirect
    logic        branch_i;
    logic [31:0] branch_addr_i;
    // ID stage side
    logic        id_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_aligned_o;
    logic        instr_compressed_o;
    logic        instr_misaligned_o;
    logic [31:0] pc_o;

    modport slave (
        input  fetch_valid_i,
        input  fetch_rdata_i,
        output fetch_ready_o,
        input  branch_i,
        input  branch_addr_i,
        input  id_ready_i,
        output instr_valid_o,
        output instr_aligned_o,
        output instr_compressed_o,
        output instr_misaligned_o,
        output pc_o
    );

    modport master (
        output fetch_valid_i,
        output fetch_rdata_i,
        input  fetch_ready_o,
        output branch_i,
        output branch_addr_i,
        output id_ready_i,
        input  instr_valid_o,
        input  instr_aligned_o,
        input  instr_compressed_o,
        input  instr_misaligned_o,
        input  pc_o
    );
endinterface

// File: rtl/cv32e40p_fetch_aligner.sv
// Fetch aligner: turns a stream of word-aligned 32-bit fetch words into a
// stream of 16/32-bit instructions, including 32-bit instructions that straddle
// two words and branch targets at bit-1-set half-word addresses.
module cv32e40p_fetch_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic                            clk,
    input  logic                            rst,
    cv32e40p_fetch_aligner_if.slave         bus
);

    // ALIGNED: next instruction starts at bit 0 of the current fetch word
    // MIS32  : 32-bit instr = low half of current word + saved half_q
    // MIS16  : saved half_q is a complete compressed instruction
    // BR_MIS : branch landed on upper half; lower half of first word is dropped
    localparam logic [1:0] ALIGNED = 2'd0;
    localparam logic [1:0] MIS32   = 2'd1;
    localparam logic [1:0] MIS16   = 2'd2;
    localparam logic [1:0] BR_MIS  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] half_q, half_d;

    logic        instr_valid;
    logic        fetch_ready;
    logic [31:0] instr;
    logic        compressed;
    logic        misaligned;
    logic        accept;
    logic        hi_is_32;

    // Upper half of the current word begins a 32-bit instruction
    assign hi_is_32 = (bus.fetch_rdata_i[17:16] == 2'b11);

    // Output decode and next-state computation
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        half_d      = half_q;
        instr_valid = 1'b0;
        fetch_ready = 1'b0;
        instr       = bus.fetch_rdata_i;
        compressed  = 1'b0;
        misaligned  = 1'b0;
        accept      = 1'b0;

        case (state_q)
            ALIGNED: begin
                instr_valid = bus.fetch_valid_i;
                fetch_ready = bus.id_ready_i;
                accept      = bus.fetch_valid_i && bus.id_ready_i;
                if (bus.fetch_rdata_i[1:0] == 2'b11) begin
                    instr = bus.fetch_rdata_i;
                    if (accept) begin
                        pc_d = pc_q + 32'd4;
                    end
                end else begin
                    instr      = {16'h0000, bus.fetch_rdata_i[15:0]};
                    compressed = 1'b1;
                    if (accept) begin
                        half_d  = bus.fetch_rdata_i[31:16];
                        pc_d    = pc_q + 32'd2;
                        state_d = hi_is_32 ? MIS32 : MIS16;
                    end
                end
            end
            MIS32: begin
                instr       = {bus.fetch_rdata_i[15:0], half_q};
                misaligned  = 1'b1;
                instr_valid = bus.fetch_valid_i;
                fetch_ready = bus.id_ready_i;
                accept      = bus.fetch_valid_i && bus.id_ready_i;
                if (accept) begin
                    half_d  = bus.fetch_rdata_i[31:16];
                    pc_d    = pc_q + 32'd4;
                    state_d = hi_is_32 ? MIS32 : MIS16;
                end
            end
            MIS16: begin
                // Instruction is fully buffered; the current word is not needed
                instr       = {16'h0000, half_q};
                compressed  = 1'b1;
                instr_valid = 1'b1;
                fetch_ready = 1'b0;
                accept      = bus.id_ready_i;
                if (accept) begin
                    pc_d    = pc_q + 32'd2;
                    state_d = ALIGNED;
                end
            end
            default: begin // BR_MIS
                if (!hi_is_32) begin
                    instr       = {16'h0000, bus.fetch_rdata_i[31:16]};
                    compressed  = 1'b1;
                    instr_valid = bus.fetch_valid_i;
                    fetch_ready = bus.id_ready_i;
                    accept      = bus.fetch_valid_i && bus.id_ready_i;
                    if (accept) begin
                        pc_d    = pc_q + 32'd2;
                        state_d = ALIGNED;
                    end
                end else begin
                    // Only the first half of a straddling instruction: pop the
                    // word silently and complete it from the next word.
                    instr_valid = 1'b0;
                    fetch_ready = bus.fetch_valid_i;
                    if (bus.fetch_valid_i) begin
                        half_d  = bus.fetch_rdata_i[31:16];
                        state_d = MIS32;
                    end
                end
            end
        endcase

        // Redirect overrides everything; the stale word stays in the buffer
        if (bus.branch_i) begin
            instr_valid = 1'b0;
            fetch_ready = 1'b0;
            pc_d        = {bus.branch_addr_i[31:1], 1'b0};
            half_d      = 16'h0000;
            state_d     = bus.branch_addr_i[1] ? BR_MIS : ALIGNED;
        end

        // Nothing is presented or consumed while in reset
        if (rst) begin
            instr_valid = 1'b0;
            fetch_ready = 1'b0;
        end
    end

    // State, PC and saved half-word registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ALIGNED;
            pc_q    <= {BOOT_ADDR[31:1], 1'b0};
            half_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            half_q  <= half_d;
        end
    end

    assign bus.instr_valid_o      = instr_valid;
    assign bus.fetch_ready_o      = fetch_ready;
    assign bus.instr_aligned_o    = instr;
    assign bus.instr_compressed_o = compressed;
    assign bus.instr_misaligned_o = misaligned;
    assign bus.pc_o               = pc_q;

endmodule

// File: tb/tb_cv32e40p_fetch_aligner.sv
// Directed testbench for cv32e40p_fetch_aligner: linear stimulus steps with
// hand-computed expected outputs checked by immediate assertions.
module tb_cv32e40p_fetch_aligner;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cv32e40p_fetch_aligner_if bus ();

    cv32e40p_fetch_aligner #(
        .BOOT_ADDR (32'h0000_0080)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the full presented instruction plus fetch_ready and pc
    task automatic chk_instr(input string tag, input logic [31:0] ins, input logic comp,
                             input logic mis, input logic rdy, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, bus.instr_valid_o}, 32'd1);
        chk({tag, ".instr"}, bus.instr_aligned_o, ins);
        chk({tag, ".comp"},  {31'd0, bus.instr_compressed_o}, {31'd0, comp});
        chk({tag, ".mis"},   {31'd0, bus.instr_misaligned_o}, {31'd0, mis});
        chk({tag, ".ready"}, {31'd0, bus.fetch_ready_o}, {31'd0, rdy});
        chk({tag, ".pc"},    bus.pc_o, pc);
        $display("step %-10s pc=%h instr=%h c=%0b m=%0b rdy=%0b", tag, bus.pc_o,
                 bus.instr_aligned_o, bus.instr_compressed_o, bus.instr_misaligned_o,
                 bus.fetch_ready_o);
    endtask

    // Check a cycle where nothing is presented
    task automatic chk_idle(input string tag, input logic rdy) ;
        chk({tag, ".valid"}, {31'd0, bus.instr_valid_o}, 32'd0);
        chk({tag, ".ready"}, {31'd0, bus.fetch_ready_o}, {31'd0, rdy});
        $display("step %-10s pc=%h valid=0 rdy=%0b", tag, bus.pc_o, bus.fetch_ready_o);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.branch_i = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.fetch_valid_i = 1'b1;
        bus.fetch_rdata_i = 32'h00A0_0093;
        bus.branch_i      = 1'b0;
        bus.branch_addr_i = 32'h0;
        bus.id_ready_i    = 1'b1;
        #1;
        // Reset: nothing presented or popped even with valid data upstream
        chk_idle("rst", 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("rst.pc", bus.pc_o, 32'h0000_0080);

        // Two aligned 32-bit instructions
        bus.fetch_rdata_i = 32'h00A0_0093; #1;
        chk_instr("a32_0", 32'h00A0_0093, 1'b0, 1'b0, 1'b1, 32'h80);
        step();
        bus.fetch_rdata_i = 32'h0010_8113; #1;
        chk_instr("a32_1", 32'h0010_8113, 1'b0, 1'b0, 1'b1, 32'h84);
        // Stall in ALIGNED: presented but not popped, state holds
        bus.id_ready_i = 1'b0; #1;
        chk_instr("stall_a", 32'h0010_8113, 1'b0, 1'b0, 1'b0, 32'h84);
        step();
        bus.id_ready_i = 1'b1; #1;
        chk_instr("stall_a2", 32'h0010_8113, 1'b0, 1'b0, 1'b1, 32'h84);
        step();
        chk("a32.pc", bus.pc_o, 32'h88);

        // Two compressed instructions in one word
        do_reset();
        bus.fetch_rdata_i = 32'h0001_4501; #1;
        chk_instr("c16_0", 32'h0000_4501, 1'b1, 1'b0, 1'b1, 32'h80);
        step();
        bus.fetch_valid_i = 1'b0; #1;
        chk_instr("c16_1", 32'h0000_0001, 1'b1, 1'b0, 1'b0, 32'h82);
        step();
        chk_idle("c16_empty", 1'b1);
        chk("c16.pc", bus.pc_o, 32'h84);

        // 32-bit instruction straddling two words
        do_reset();
        bus.fetch_valid_i = 1'b1;
        bus.fetch_rdata_i = 32'h0093_4501; #1;
        chk_instr("mis_0", 32'h0000_4501, 1'b1, 1'b0, 1'b1, 32'h80);
        step();
        bus.fetch_rdata_i = 32'h0000_00A0; #1;
        chk_instr("mis_1", 32'h00A0_0093, 1'b0, 1'b1, 1'b1, 32'h82);
        step();
        bus.fetch_valid_i = 1'b0; #1;
        chk_instr("mis_2", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h86);

        // Branch to 0x102, upper half starts a 32-bit instruction
        bus.fetch_valid_i = 1'b1;
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h0000_0102; #1;
        chk_idle("br_0", 1'b0);
        step();
        bus.branch_i      = 1'b0;
        bus.fetch_rdata_i = 32'h0093_1234; #1;
        chk_idle("br_pop", 1'b1);
        chk("br_pop.pc", bus.pc_o, 32'h102);
        step();
        bus.fetch_rdata_i = 32'h0000_00A0; #1;
        chk_instr("br_mis", 32'h00A0_0093, 1'b0, 1'b1, 1'b1, 32'h102);
        step();
        chk("br_mis.pc", bus.pc_o, 32'h106);

        // Branch to 0x102, upper half is compressed
        bus.branch_i = 1'b1; #1;
        chk_idle("br2_0", 1'b0);
        step();
        bus.branch_i      = 1'b0;
        bus.fetch_rdata_i = 32'h4505_1234; #1;
        chk_instr("br2_c", 32'h0000_4505, 1'b1, 1'b0, 1'b1, 32'h102);
        step();
        chk("br2.pc", bus.pc_o, 32'h104);

        // Branch with bit 0 set to the last half-word: wraps to 0
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'hFFFF_FFFF; #1;
        step();
        bus.branch_i      = 1'b0;
        bus.fetch_rdata_i = 32'h0001_1234; #1;
        chk_instr("wrap", 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step();
        chk("wrap.pc", bus.pc_o, 32'h0);

        // Branch during a stall in MIS16
        do_reset();
        bus.fetch_rdata_i = 32'h0001_4501; #1;
        step();
        bus.id_ready_i = 1'b0; #1;
        chk_instr("stall16", 32'h0000_0001, 1'b1, 1'b0, 1'b0, 32'h82);
        step();
        chk_instr("stall16b", 32'h0000_0001, 1'b1, 1'b0, 1'b0, 32'h82);
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 32'h0000_0200; #1;
        chk_idle("br_stall", 1'b0);
        step();
        bus.branch_i      = 1'b0;
        bus.id_ready_i    = 1'b1;
        bus.fetch_rdata_i = 32'h00A0_0093; #1;
        chk_instr("br_stall2", 32'h00A0_0093, 1'b0, 1'b0, 1'b1, 32'h200);

        // Reset while in MIS32 with valid data
        do_reset();
        bus.fetch_rdata_i = 32'h0093_4501; #1;
        step();
        bus.fetch_rdata_i = 32'h0000_00A0;
        rst = 1'b1;
        bus.branch_i = 1'b1;
        bus.branch_addr_i = 32'h0000_0300; #1;
        chk_idle("rst_mis", 1'b0);
        step();
        rst = 1'b0;
        bus.branch_i = 1'b0;
        bus.fetch_rdata_i = 32'h00A0_0093; #1;
        chk_instr("rst_mis2", 32'h00A0_0093, 1'b0, 1'b0, 1'b1, 32'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
